// File: rtl/snake_pkg.sv
// Shared constants and types for the snake body controller.
// Defining SNAKE_SELF_HIT_EN adds the self-collision SCAN state.
package snake_pkg;

    localparam int CW          = 7;
    localparam int XSIZE       = 60;
    localparam int YSIZE       = 80;
    localparam int DEF_MAX_LEN = 64;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

`ifdef SNAKE_SELF_HIT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/snake_ring_buf.sv
// Circular segment store: head pointer, logical-to-physical addressing,
// one write port (push at head) and one combinational read port.
import snake_pkg::*;

module snake_ring_buf #(
    parameter int MAX_LEN  = 64,
    parameter int CW       = 7,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 30,
    parameter int START_Y  = 40
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [CW-1:0]              push_x_i,
    input  logic [CW-1:0]              push_y_i,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx_i,
    output logic [CW-1:0]              rd_x_o,
    output logic [CW-1:0]              rd_y_o
);

    localparam int AW = $clog2(MAX_LEN);

    logic [CW-1:0] mem_x_q [MAX_LEN];
    logic [CW-1:0] mem_y_q [MAX_LEN];
    logic [AW-1:0] hptr_q;
    logic [AW-1:0] hptr_inc;
    logic [AW-1:0] rd_addr;

    // Reset image: physical slot INIT_LEN-1 holds the head, lower slots the body.
    function automatic logic [CW-1:0] init_x(input int k);
        if (k < INIT_LEN) return CW'(START_X - (INIT_LEN - 1 - k));
        return '0;
    endfunction

    function automatic logic [CW-1:0] init_y(input int k);
        if (k < INIT_LEN) return CW'(START_Y);
        return '0;
    endfunction

    assign hptr_inc = hptr_q + AW'(1);
    assign rd_addr  = hptr_q - rd_idx_i;
    assign rd_x_o   = mem_x_q[rd_addr];
    assign rd_y_o   = mem_y_q[rd_addr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hptr_q <= AW'(INIT_LEN - 1);
            for (int k = 0; k < MAX_LEN; k++) begin
                mem_x_q[k] <= init_x(k);
                mem_y_q[k] <= init_y(k);
            end
        end else if (clear_i) begin
            hptr_q <= AW'(INIT_LEN - 1);
            for (int k = 0; k < MAX_LEN; k++) begin
                mem_x_q[k] <= init_x(k);
                mem_y_q[k] <= init_y(k);
            end
        end else if (push_i) begin
            hptr_q            <= hptr_inc;
            mem_x_q[hptr_inc] <= push_x_i;
            mem_y_q[hptr_inc] <= push_y_i;
        end
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: accepts move steps, optionally scans for self-collision
// (SNAKE_SELF_HIT_EN), commits the new head and serves display reads while idle.
import snake_pkg::*;

module snake_body_ctrl #(
    parameter int MAX_LEN  = snake_pkg::DEF_MAX_LEN,
    parameter int CW       = snake_pkg::CW,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 30,
    parameter int START_Y  = 40
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Clear,
    input  logic                       i_Step_Valid,
    input  logic [CW-1:0]              i_Head_x,
    input  logic [CW-1:0]              i_Head_y,
    input  logic                       i_Grow,
    output logic                       o_Ready,
    output logic                       o_Done,
    output logic                       o_Hit,
    output logic                       o_Full,
    output logic [$clog2(MAX_LEN):0]   o_Len,
    input  logic [$clog2(MAX_LEN)-1:0] i_Rd_Idx,
    output logic [CW-1:0]              o_Rd_x,
    output logic [CW-1:0]              o_Rd_y,
    output logic                       o_Rd_Valid
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;

    // Handshake: a step is taken on a cycle where i_Step_Valid && o_Ready;
    // o_Ready is high only in IDLE, and requests at other times are dropped.

    state_e        state_q, state_d;
    logic [CW-1:0] head_x_q, head_x_d;
    logic [CW-1:0] head_y_q, head_y_d;
    logic          geff_q, geff_d;
    logic [LW-1:0] len_q, len_d;
    logic          push;
    logic          accept;
    logic          full;
    logic          geff_in;
    logic [AW-1:0] buf_idx;
    logic [CW-1:0] buf_x, buf_y;
    logic [CW-1:0] rd_x_q, rd_y_q;
    logic          rd_valid_q;

`ifdef SNAKE_SELF_HIT_EN
    logic [LW-1:0] n_q, n_d, n_in;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          hit_res_q, hit_res_d;

    // On a plain move the tail vacates this step, so it is not checked.
    assign n_in    = geff_in ? len_q : len_q - LW'(1);
    assign buf_idx = (state_q == ST_SCAN) ? cnt_q : i_Rd_Idx;
    assign o_Hit   = hit_res_q;
`else
    assign buf_idx = i_Rd_Idx;
    assign o_Hit   = 1'b0;
`endif

    assign full    = (len_q == LW'(MAX_LEN));
    assign accept  = i_Step_Valid && (state_q == ST_IDLE);
    assign geff_in = i_Grow && !full;

    assign o_Ready    = (state_q == ST_IDLE);
    assign o_Done     = (state_q == ST_DONE);
    assign o_Full     = full;
    assign o_Len      = len_q;
    assign o_Rd_x     = rd_x_q;
    assign o_Rd_y     = rd_y_q;
    assign o_Rd_Valid = rd_valid_q;

    snake_ring_buf #(
        .MAX_LEN  (MAX_LEN),
        .CW       (CW),
        .INIT_LEN (INIT_LEN),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) u_ring (
        .clk_i    (i_Clk),
        .rst_ni   (i_Rst),
        .clear_i  (i_Clear),
        .push_i   (push),
        .push_x_i (head_x_q),
        .push_y_i (head_y_q),
        .rd_idx_i (buf_idx),
        .rd_x_o   (buf_x),
        .rd_y_o   (buf_y)
    );

    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        geff_d   = geff_q;
        len_d    = len_q;
        push     = 1'b0;
`ifdef SNAKE_SELF_HIT_EN
        n_d       = n_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        hit_res_d = hit_res_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    head_x_d = i_Head_x;
                    head_y_d = i_Head_y;
                    geff_d   = geff_in;
`ifdef SNAKE_SELF_HIT_EN
                    n_d       = n_in;
                    cnt_d     = '0;
                    hit_d     = 1'b0;
                    hit_res_d = 1'b0;
                    state_d   = (n_in == '0) ? ST_COMMIT : ST_SCAN;
`else
                    state_d  = ST_COMMIT;
`endif
                end
            end
`ifdef SNAKE_SELF_HIT_EN
            ST_SCAN: begin
                hit_d = hit_q | ((buf_x == head_x_q) && (buf_y == head_y_q));
                cnt_d = cnt_q + AW'(1);
                if ({1'b0, cnt_q} == n_q - LW'(1)) state_d = ST_COMMIT;
            end
`endif
            ST_COMMIT: begin
`ifdef SNAKE_SELF_HIT_EN
                hit_res_d = hit_q;
                if (!hit_q) begin
                    push  = 1'b1;
                    len_d = len_q + LW'(geff_q);
                end
`else
                push  = 1'b1;
                len_d = len_q + LW'(geff_q);
`endif
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= ST_IDLE;
            head_x_q <= '0;
            head_y_q <= '0;
            geff_q   <= 1'b0;
            len_q    <= LW'(INIT_LEN);
`ifdef SNAKE_SELF_HIT_EN
            n_q       <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            hit_res_q <= 1'b0;
`endif
        end else if (i_Clear) begin
            state_q  <= ST_IDLE;
            head_x_q <= '0;
            head_y_q <= '0;
            geff_q   <= 1'b0;
            len_q    <= LW'(INIT_LEN);
`ifdef SNAKE_SELF_HIT_EN
            n_q       <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            hit_res_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            geff_q   <= geff_d;
            len_q    <= len_d;
`ifdef SNAKE_SELF_HIT_EN
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            hit_res_q <= hit_res_d;
`endif
        end
    end

    // Display port: only IDLE cycles update the read registers.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
        end else if (i_Clear) begin
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == ST_IDLE) && ({1'b0, i_Rd_Idx} < len_q);
            if (state_q == ST_IDLE) begin
                rd_x_q <= buf_x;
                rd_y_q <= buf_y;
            end
        end
    end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl with a 4-deep body buffer.
module tb_snake_body_ctrl;

    localparam int MAX_LEN = 4;
    localparam int CW      = 7;
    localparam int AW      = 2;
    localparam int LW      = 3;
    localparam int EW      = 1 + LW;
`ifdef SNAKE_SELF_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          step_valid;
    logic [CW-1:0] head_x, head_y;
    logic          grow;
    logic [AW-1:0] rd_idx;
    logic          ready, done, hit, full, rd_valid;
    logic [LW-1:0] len;
    logic [CW-1:0] rd_x, rd_y;

    logic [2*CW-1:0] model_q[$];
    logic [EW-1:0]   exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    snake_body_ctrl #(
        .MAX_LEN  (MAX_LEN),
        .CW       (CW),
        .INIT_LEN (3),
        .START_X  (30),
        .START_Y  (40)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst_n),
        .i_Clear      (clear),
        .i_Step_Valid (step_valid),
        .i_Head_x     (head_x),
        .i_Head_y     (head_y),
        .i_Grow       (grow),
        .o_Ready      (ready),
        .o_Done       (done),
        .o_Hit        (hit),
        .o_Full       (full),
        .o_Len        (len),
        .i_Rd_Idx     (rd_idx),
        .o_Rd_x       (rd_x),
        .o_Rd_y       (rd_y),
        .o_Rd_Valid   (rd_valid)
    );

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) model_q.push_back({CW'(30 - k), CW'(40)});
    endtask

    task automatic check_reads();
        logic exp_v;
        for (int i = 0; i < MAX_LEN; i++) begin
            rd_idx = AW'(i);
            @(negedge clk);
            exp_v = (i < model_q.size());
            n_tests++;
            if (rd_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rd_valid idx=%0d got=%b exp=%b", i, rd_valid, exp_v);
            end
            if (exp_v) begin
                n_tests++;
                if ({rd_x, rd_y} !== model_q[i]) begin
                    n_fail++;
                    $display("FAIL rd_data idx=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, rd_x, rd_y,
                             model_q[i][2*CW-1:CW], model_q[i][CW-1:0]);
                end
            end
        end
    endtask

    task automatic do_step(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic g,
                           input bit hold_busy);
        int sz, n, lat, k, done_at;
        logic exp_hit, geff;
        logic [EW-1:0] exp_e;
        k = 0;
        @(negedge clk);
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait got=%b exp=1", ready);
        end
        sz   = model_q.size();
        geff = g && (sz != MAX_LEN);
        n    = geff ? sz : sz - 1;
        exp_hit = 1'b0;
        if (HIT_EN)
            for (int i = 0; i < n; i++) if (model_q[i] == {x, y}) exp_hit = 1'b1;
        lat = HIT_EN ? n + 2 : 2;
        if (!exp_hit) begin
            model_q.push_front({x, y});
            if (!geff) void'(model_q.pop_back());
        end
        exp_q.push_back({exp_hit, LW'(model_q.size())});

        step_valid = 1'b1;
        head_x = x;
        head_y = y;
        grow = g;
        @(posedge clk);
        done_at = 0;
        k = 1;
        while (done_at == 0 && k <= 40) begin
            @(negedge clk);
            if (!hold_busy) step_valid = 1'b0;
            else begin
                head_x = ~x;
                head_y = ~y;
                grow = ~g;
            end
            if (done === 1'b1) begin
                done_at = k;
                step_valid = 1'b0;
            end
            k++;
        end
        exp_e = exp_q.pop_front();
        n_tests++;
        if (done_at != lat) begin
            n_fail++;
            $display("FAIL step_latency (%0d,%0d) got=%0d exp=%0d", x, y, done_at, lat);
        end
        n_tests++;
        if ({hit, len} !== exp_e) begin
            n_fail++;
            $display("FAIL step_result (%0d,%0d) got hit=%b len=%0d exp hit=%b len=%0d",
                     x, y, hit, len, exp_e[EW-1], exp_e[LW-1:0]);
        end
        n_tests++;
        if (full !== (model_q.size() == MAX_LEN)) begin
            n_fail++;
            $display("FAIL full got=%b exp=%b", full, model_q.size() == MAX_LEN);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || hit !== exp_e[EW-1]) begin
            n_fail++;
            $display("FAIL done_pulse/hit_hold got done=%b hit=%b exp done=0 hit=%b",
                     done, hit, exp_e[EW-1]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        step_valid = 1'b0;
        head_x = '0;
        head_y = '0;
        grow = 1'b0;
        rd_idx = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({done, hit, rd_valid, rd_x, rd_y} !== '0 || len !== LW'(3)) begin
            n_fail++;
            $display("FAIL reset_outputs got done=%b hit=%b rv=%b rd=(%0d,%0d) len=%0d exp zeros len=3",
                     done, hit, rd_valid, rd_x, rd_y, len);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got ready=%b full=%b exp ready=1 full=0", ready, full);
        end
        check_reads();
    endtask

    task automatic test_move();
        do_step(CW'(31), CW'(40), 1'b0, 1'b0);
        check_reads();
    endtask

    task automatic test_grow();
        do_step(CW'(31), CW'(41), 1'b1, 1'b0);
        check_reads();
    endtask

    task automatic test_full();
        do_step(CW'(32), CW'(41), 1'b1, 1'b0);
        check_reads();
        do_step(CW'(33), CW'(41), 1'b0, 1'b0);
        do_step(CW'(31), CW'(40), 1'b1, 1'b0);
        check_reads();
    endtask

    task automatic test_back_to_back();
        int extra;
        do_step(CW'(34), CW'(41), 1'b0, 1'b1);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL busy_request_done_count got=%0d extra pulses exp=0", extra);
        end
        check_reads();
    endtask

    task automatic test_hit();
        do_reset();
        do_step(CW'(29), CW'(40), 1'b0, 1'b0);
        check_reads();
        do_step(CW'(28), CW'(40), 1'b0, 1'b0);
        check_reads();
    endtask

    task automatic test_abort(input bit use_clear);
        int seen;
        do_step(CW'(40), CW'(10), 1'b1, 1'b0);
        @(negedge clk);
        step_valid = 1'b1;
        head_x = CW'(41);
        head_y = CW'(10);
        grow = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step_valid = 1'b0;
        if (use_clear) clear = 1'b1;
        else rst_n = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0 || len !== LW'(3) || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort clear=%0d got done_pulses=%0d len=%0d ready=%b exp 0/3/1",
                     use_clear, seen, len, ready);
        end
        check_reads();
    endtask

    initial begin
        test_reset();
        test_move();
        test_grow();
        test_full();
        test_back_to_back();
        test_hit();
        test_abort(1'b0);
        test_abort(1'b1);
        do_step(CW'(31), CW'(40), 1'b0, 1'b0);
        check_reads();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
